// File: rtl/piso_tx_arbiter_if.sv
// Handshake and PISO control bundle for piso_tx_arbiter.
// The slave modport is the arbiter's view; master is the requester/consumer side.
interface piso_tx_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 6
);
    logic                  enable;
    logic                  req0_valid;
    logic [DATA_WIDTH-1:0] req0_data;
    logic [LEN_WIDTH-1:0]  req0_len;
    logic                  req0_ready;
    logic                  req1_valid;
    logic [DATA_WIDTH-1:0] req1_data;
    logic [LEN_WIDTH-1:0]  req1_len;
    logic                  req1_ready;
    logic                  piso_enable;
    logic                  piso_load;
    logic                  piso_shift;
    logic [DATA_WIDTH-1:0] piso_data;
    logic                  frame_active;
    logic                  frame_start;
    logic                  frame_end;
    logic                  abort;
    logic                  grant_id;
    logic                  busy;

    modport slave (
        input  enable,
        input  req0_valid, req0_data, req0_len,
        output req0_ready,
        input  req1_valid, req1_data, req1_len,
        output req1_ready,
        output piso_enable, piso_load, piso_shift, piso_data,
        output frame_active, frame_start, frame_end, abort,
        output grant_id, busy
    );

    modport master (
        output enable,
        output req0_valid, req0_data, req0_len,
        input  req0_ready,
        output req1_valid, req1_data, req1_len,
        input  req1_ready,
        input  piso_enable, piso_load, piso_shift, piso_data,
        input  frame_active, frame_start, frame_end, abort,
        input  grant_id, busy
    );
endinterface

// File: rtl/piso_tx_arbiter.sv
// Two-requester round-robin transmit scheduler driving a falling-edge PISO.
// A frame is one LOAD cycle followed by L-1 SHIFT cycles, then an optional gap.
module piso_tx_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 6,
    parameter int GAP_CYCLES = 1
) (
    input logic               clk,
    input logic               rst_n,
    piso_tx_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_e;

    localparam logic [LEN_WIDTH-1:0] FULL_LEN = LEN_WIDTH'(DATA_WIDTH);

    state_e                state;
    state_e                state_next;
    logic                  rr_ptr;      // requester preferred on the next tie
    logic                  grant_q;
    logic                  enable_q;
    logic                  abort_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [LEN_WIDTH-1:0]  bit_cnt;     // bits still to present, including current
    logic [3:0]            gap_cnt;
    logic                  pick0;
    logic                  pick1;
    logic                  accept0;
    logic                  accept1;
    logic                  in_frame;
    logic                  last_bit;

    // Zero and oversize lengths both mean a full-width word.
    function automatic logic [LEN_WIDTH-1:0] eff_len(input logic [LEN_WIDTH-1:0] len);
        if (len == '0 || len > FULL_LEN) begin
            return FULL_LEN;
        end
        return len;
    endfunction

    assign pick0    = bus.req0_valid & (~bus.req1_valid | ~rr_ptr);
    assign pick1    = bus.req1_valid & (~bus.req0_valid | rr_ptr);
    // Reset is folded in so Ready stays low while the block is held in reset.
    assign accept0  = rst_n & bus.enable & (state == IDLE) & pick0;
    assign accept1  = rst_n & bus.enable & (state == IDLE) & pick1;
    assign in_frame = (state == LOAD) || (state == SHIFT);
    assign last_bit = in_frame && (bit_cnt == LEN_WIDTH'(1));

    assign bus.req0_ready   = accept0;
    assign bus.req1_ready   = accept1;
    assign bus.piso_enable  = enable_q;
    assign bus.piso_load    = (state == LOAD);
    assign bus.piso_shift   = (state == SHIFT);
    assign bus.piso_data    = data_q;
    assign bus.frame_active = in_frame;
    assign bus.frame_start  = (state == LOAD);
    // A frame cut short by Enable never reports an end.
    assign bus.frame_end    = last_bit & bus.enable;
    assign bus.abort        = abort_q;
    assign bus.grant_id     = grant_q;
    assign bus.busy         = (state != IDLE);

    // Next-state selection for the frame sequencer.
    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept0 || accept1) begin
                    state_next = LOAD;
                end
            end
            LOAD, SHIFT: begin
                if (!bus.enable) begin
                    state_next = IDLE;
                end else if (last_bit) begin
                    state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    state_next = SHIFT;
                end
            end
            GAP: begin
                if (!bus.enable || gap_cnt == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state <= state_next;
        end
    end

    // Capture of the accepted request, bit/gap counting and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q <= 1'b0;
            abort_q  <= 1'b0;
            rr_ptr   <= 1'b0;
            grant_q  <= 1'b0;
            data_q   <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            enable_q <= bus.enable;
            abort_q  <= in_frame & ~bus.enable;

            if (accept0) begin
                data_q  <= bus.req0_data;
                bit_cnt <= eff_len(bus.req0_len);
                grant_q <= 1'b0;
                rr_ptr  <= 1'b1;
            end else if (accept1) begin
                data_q  <= bus.req1_data;
                bit_cnt <= eff_len(bus.req1_len);
                grant_q <= 1'b1;
                rr_ptr  <= 1'b0;
            end else if (in_frame) begin
                bit_cnt <= bit_cnt - LEN_WIDTH'(1);
            end

            if (state_next == GAP && state != GAP) begin
                gap_cnt <= 4'(GAP_CYCLES - 1);
            end else if (state == GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

endmodule
